// File: rtl/mag_compare_seq.sv
// Sequential magnitude comparator: walks two unsigned operands two bits at a
// time from the MSB slice down and stops at the first unequal slice.
module mag_compare_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int NS = WIDTH / 2;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(NS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             done_q, done_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;

    logic [1:0] sa, sb;
    logic       sl_l, sl_g, sl_e;

    // 2-bit slice compare on the slice currently addressed by idx
    always_comb begin
        sa   = a_q[{idx_q, 1'b0} +: 2];
        sb   = b_q[{idx_q, 1'b0} +: 2];
        sl_l = (~sa[1] & sb[1]) | (~sa[1] & ~sa[0] & sb[0]) | (~sa[0] & sb[1] & sb[0]);
        sl_g = (sa[1] & ~sb[1]) | (sa[1] & sa[0] & ~sb[0]) | (sa[0] & ~sb[1] & ~sb[0]);
        sl_e = (sa == sb);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IDX_TOP;
                    state_d = RUN;
                end
            end
            RUN: begin
                // abort wins over the slice result and leaves results untouched
                if (abort) begin
                    state_d = IDLE;
                end else if (!sl_e) begin
                    lt_d    = sl_l;
                    gt_d    = sl_g;
                    eq_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (idx_q == '0) begin
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    eq_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign lt   = lt_q;
    assign eq   = eq_q;
    assign gt   = gt_q;

endmodule

// File: tb/tb_mag_compare_seq.sv
// Bench for mag_compare_seq (WIDTH=8): scenario tasks with a scoreboard queue
// of expected {lt,eq,gt} results and latencies.
module tb_mag_compare_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, lt, eq, gt;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] leg;
        int         k;
    } exp_t;

    exp_t sbq[$];

    localparam logic [2:0] R_LT = 3'b100;
    localparam logic [2:0] R_EQ = 3'b010;
    localparam logic [2:0] R_GT = 3'b001;

    mag_compare_seq #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .lt   (lt),
        .eq   (eq),
        .gt   (gt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Wait (from the negedge after the start edge) for done; pop and check.
    task automatic wait_and_check(input string nm);
        int   n;
        exp_t e;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s timeout: done not seen within %0d cycles", nm, n);
            return;
        end
        if (sbq.size() == 0) begin
            failures++;
            $display("FAIL %s unexpected done: scoreboard empty", nm);
            return;
        end
        e = sbq.pop_front();
        checks++;
        if ({lt, eq, gt} !== e.leg) begin
            failures++;
            $display("FAIL %s result: got lt/eq/gt=%b expected %b", nm, {lt, eq, gt}, e.leg);
        end
        checks++;
        if (n !== e.k) begin
            failures++;
            $display("FAIL %s latency: got %0d expected %0d", nm, n, e.k);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_in_done: got %b expected 0", nm, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL %s done_width: got %b expected 0 one cycle later", nm, done);
        end
    endtask

    task automatic do_cmp(input logic [7:0] av, input logic [7:0] bv,
                          input logic [2:0] leg, input int k, input string nm);
        exp_t e;
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        e.leg = leg;
        e.k = k;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_after_start: got busy=%b done=%b expected busy=1 done=0", nm, busy, done);
        end
        wait_and_check(nm);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, lt, eq, gt} !== 5'b0) begin
            failures++;
            $display("FAIL reset_values: got busy/done/lt/eq/gt=%b expected 00000", {busy, done, lt, eq, gt});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, lt, eq, gt} !== 5'b0) begin
            failures++;
            $display("FAIL reset_release: got %b expected 00000", {busy, done, lt, eq, gt});
        end
    endtask

    task automatic test_equal();
        do_cmp(8'hA5, 8'hA5, R_EQ, 4, "equal_A5");
    endtask

    task automatic test_msb();
        do_cmp(8'h80, 8'h7F, R_GT, 1, "msb_gt");
        do_cmp(8'h7F, 8'h80, R_LT, 1, "msb_lt");
    endtask

    task automatic test_lsb();
        do_cmp(8'h12, 8'h13, R_LT, 4, "lsb_lt");
        do_cmp(8'hFF, 8'hFC, R_GT, 4, "lsb_gt");
        do_cmp(8'h9C, 8'h9C, R_EQ, 4, "equal_9C");
        do_cmp(8'h2F, 8'h3F, R_LT, 2, "slice2_lt");
    endtask

    task automatic test_start_busy();
        exp_t e;
        int   n;
        int   extra;
        @(negedge clk);
        a = 8'h00;
        b = 8'h00;
        start = 1'b1;
        e.leg = R_EQ;
        e.k = 4;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 8'hFF;
        b = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 2;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done || n !== 4) begin
            failures++;
            $display("FAIL start_busy latency: got done=%b after %0d cycles expected 4", done, n);
        end
        e = sbq.pop_front();
        checks++;
        if ({lt, eq, gt} !== e.leg) begin
            failures++;
            $display("FAIL start_busy result: got %b expected %b", {lt, eq, gt}, e.leg);
        end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL start_busy second_compare: got %0d busy/done cycles expected 0", extra);
        end
    endtask

    task automatic test_abort();
        int dcount;
        do_cmp(8'hC0, 8'h40, R_GT, 1, "pre_abort_gt");
        @(negedge clk);
        a = 8'h55;
        b = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
        checks++;
        if ({lt, eq, gt} !== R_GT) begin
            failures++;
            $display("FAIL abort_hold: got %b expected %b", {lt, eq, gt}, R_GT);
        end
        dcount = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        checks++;
        if (dcount !== 0) begin
            failures++;
            $display("FAIL abort_no_done: got %0d done pulses expected 0", dcount);
        end
    endtask

    task automatic test_reset_mid();
        int dcount;
        @(negedge clk);
        a = 8'h55;
        b = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid running: got busy=%b expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, lt, eq, gt} !== 5'b0) begin
            failures++;
            $display("FAIL reset_mid outputs: got %b expected 00000", {busy, done, lt, eq, gt});
        end
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        checks++;
        if (dcount !== 0) begin
            failures++;
            $display("FAIL reset_mid no_done: got %0d busy/done cycles expected 0", dcount);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        @(negedge clk);
        a = 8'h40;
        b = 8'h30;
        start = 1'b1;
        e.leg = R_GT;
        e.k = 1;
        sbq.push_back(e);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b first_busy: got busy=%b done=%b expected 1 0", busy, done);
        end
        a = 8'h30;
        b = 8'h40;
        e.leg = R_LT;
        sbq.push_back(e);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b first_done: got done=%b busy=%b expected 1 0", done, busy);
        end
        e = sbq.pop_front();
        checks++;
        if ({lt, eq, gt} !== e.leg) begin
            failures++;
            $display("FAIL b2b first_result: got %b expected %b", {lt, eq, gt}, e.leg);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b second_busy: got busy=%b done=%b expected 1 0", busy, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b second_done: got done=%b busy=%b expected 1 0", done, busy);
        end
        e = sbq.pop_front();
        checks++;
        if ({lt, eq, gt} !== e.leg) begin
            failures++;
            $display("FAIL b2b second_result: got %b expected %b", {lt, eq, gt}, e.leg);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b settle: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_msb();
        test_lsb();
        test_start_busy();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (sbq.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
